cpu_timer: RTL

- DMG timer peripheral sitting directly downstream of the CPU on the system bus.
- Decodes FF04–FF07 (DIV, TIMA, TMA, TAC) from the CPU's mem_addr/mem_enable/mem_write/mem_data_out and returns read data for the bus mux.
- Runs the 16-bit system counter every clk and raises a one-clk timer interrupt request toward the interrupt-flag logic.
- All state advances in lockstep with the CPU's T-cycle phase.

---
 rtl/cpu_timer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cpu_timer.sv
// -----------------------------------------------------------------------------
// cpu_timer
//   DMG timer peripheral on the CPU system bus. Decodes DIV/TIMA/TMA/TAC at
//   FF04..FF07, runs the 16-bit system counter every clk and raises a one-clk
//   timer interrupt request after the delayed TIMA reload that follows an
//   overflow.
//
// Ports
//   clk           system clock, shared with the cpu
//   reset         synchronous, active-high reset
//   t_cycle       cpu T-cycle phase 0..3; bus writes commit when it is 3
//   mem_addr      bus address
//   mem_enable    bus access enable
//   mem_write     bus write enable
//   mem_data_in   bus write data
//   mem_data_out  read data (combinational, FF when not selected)
//   mem_selected  high when mem_enable and mem_addr is in FF04..FF07
//   irq_timer     registered one-clk interrupt request pulse
// -----------------------------------------------------------------------------
module cpu_timer #(
  parameter logic [15:0] COUNTER_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] mem_addr,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  mem_data_out,
  output logic        mem_selected,
  output logic        irq_timer
);

  typedef enum logic [1:0] {
    REG_DIV  = 2'd0,
    REG_TIMA = 2'd1,
    REG_TMA  = 2'd2,
    REG_TAC  = 2'd3
  } timer_reg_e;

  logic [15:0] counter_q, counter_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        reload_pending_q, reload_pending_d;
  logic [1:0]  reload_cnt_q, reload_cnt_d;
  logic        irq_q, irq_d;

  logic        addr_hit;
  timer_reg_e  reg_sel;
  logic        wr;
  logic        wr_div, wr_tima, wr_tma, wr_tac;
  logic        tima_inc;
  logic        reload_edge;

  // FF04..FF07 share address bits [15:2]; bits [1:0] pick the register.
  assign addr_hit     = (mem_addr[15:2] == 14'h3FC1);
  assign reg_sel      = timer_reg_e'(mem_addr[1:0]);
  assign mem_selected = mem_enable & addr_hit;

  assign wr      = mem_selected & mem_write & (t_cycle == 2'd3);
  assign wr_div  = wr & (reg_sel == REG_DIV);
  assign wr_tima = wr & (reg_sel == REG_TIMA);
  assign wr_tma  = wr & (reg_sel == REG_TMA);
  assign wr_tac  = wr & (reg_sel == REG_TAC);

  // Timer tick: enable bit ANDed with the counter bit chosen by tac[1:0].
  function automatic logic tick_of(input logic [15:0] cnt, input logic [2:0] tac);
    logic sel_bit;
    case (tac[1:0])
      2'b00:   sel_bit = cnt[9];
      2'b01:   sel_bit = cnt[3];
      2'b10:   sel_bit = cnt[5];
      default: sel_bit = cnt[7];
    endcase
    return tac[2] & sel_bit;
  endfunction

  // Read mux.
  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_data_out = 8'hFF;
    if (mem_selected) begin
      case (reg_sel)
        REG_DIV:  mem_data_out = counter_q[15:8];
        REG_TIMA: mem_data_out = tima_q;
        REG_TMA:  mem_data_out = tma_q;
        default:  mem_data_out = {5'b11111, tac_q};
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    counter_d = wr_div ? 16'h0000 : counter_q + 16'd1;
    tac_d     = wr_tac ? mem_data_in[2:0] : tac_q;
    tma_d     = wr_tma ? mem_data_in : tma_q;

    // Falling edge of the tick signal, judged from pre-edge and post-edge
    // counter/tac. This deliberately makes DIV writes, clearing the enable and
    // switching the select bit able to produce a spurious increment.
    tima_inc    = tick_of(counter_q, tac_q) & ~tick_of(counter_d, tac_d);
    reload_edge = reload_pending_q & (reload_cnt_q == 2'd3);

    tima_d           = tima_q;
    reload_pending_d = reload_pending_q;
    reload_cnt_d     = reload_cnt_q;
    irq_d            = reload_edge;

    if (reload_edge) begin
      // Reload wins over a TIMA write and picks up a same-edge TMA write.
      tima_d           = tma_d;
      reload_pending_d = 1'b0;
    end else if (wr_tima) begin
      // A TIMA write beats an increment and cancels a pending reload.
      tima_d           = mem_data_in;
      reload_pending_d = 1'b0;
    end else begin
      if (tima_inc) begin
        tima_d = tima_q + 8'd1;
        if (tima_q == 8'hFF && !reload_pending_q) begin
          reload_pending_d = 1'b1;
          reload_cnt_d     = 2'd0;
        end
      end
      if (reload_pending_q) begin
        reload_cnt_d = reload_cnt_q + 2'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q        <= COUNTER_RESET;
      tima_q           <= 8'h00;
      tma_q            <= 8'h00;
      tac_q            <= 3'b000;
      reload_pending_q <= 1'b0;
      reload_cnt_q     <= 2'd0;
      irq_q            <= 1'b0;
    end else begin
      counter_q        <= counter_d;
      tima_q           <= tima_d;
      tma_q            <= tma_d;
      tac_q            <= tac_d;
      reload_pending_q <= reload_pending_d;
      reload_cnt_q     <= reload_cnt_d;
      irq_q            <= irq_d;
    end
  end

  assign irq_timer = irq_q;

endmodule
